// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP adder arbiter slice:
//   - default FP format (K total bits, W exponent bits, T fraction bits)
//   - tag record carried alongside an operation through the adder latency
//   - helper giving the requester-ID width for a requester count
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int unsigned K_DEF = 64;
    localparam int unsigned W_DEF = 11;
    localparam int unsigned T_DEF = 52;

    // Widest ID needed for the largest supported requester count (16).
    localparam int unsigned TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // ID width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpu_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpu_add_arbiter_if
// Bundles the requester side, the shared adder side and the response side of
// the FP adder arbiter.
//   slave  : view used by the arbiter (requests/adder results in, grants,
//            adder operands, responses and busy out)
//   master : view used by requesters and the adder model
// ---------------------------------------------------------------------------
interface fpu_add_arbiter_if
    import fpu_pkg::*;
#(
    parameter int unsigned K     = K_DEF,
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = id_width(N_REQ);

    // requester side
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0][K-1:0]   req_a;
    logic [N_REQ-1:0][K-1:0]   req_b;
    logic [N_REQ-1:0]          req_ready;
    logic                      hold;
    logic [N_REQ-1:0]          busy;

    // shared adder side
    logic                      add_valid;
    logic [K-1:0]              add_a;
    logic [K-1:0]              add_b;
    logic [K-1:0]              add_res;
    logic                      add_ovf;

    // response side
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [K-1:0]              rsp_data;
    logic                      rsp_ovf;

    modport slave (
        input  req_valid, req_a, req_b, hold, add_res, add_ovf,
        output req_ready, busy, add_valid, add_a, add_b,
               rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    modport master (
        output req_valid, req_a, req_b, hold, add_res, add_ovf,
        input  req_ready, busy, add_valid, add_a, add_b,
               rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: starting at ptr_i and wrapping modulo N,
// the first set bit of eligible_i wins.
//   eligible_i    : N-bit eligibility vector
//   ptr_i         : index where the search starts
//   grant_o       : one-hot winner (all zero when nobody is eligible)
//   grant_idx_o   : binary index of the winner (0 when no grant)
//   grant_valid_o : a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_valid_o
);

    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr_i < N and off < N, so one subtraction performs the wrap.
            idx = 32'(ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_valid_o && eligible_i[IW'(idx)]) begin
                grant_valid_o        = 1'b1;
                grant_o[IW'(idx)]    = 1'b1;
                grant_idx_o          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_add_arbiter
// Shares one fixed-latency pipelined FP adder among N_REQ requesters.
// Round-robin grant, at most one operation in flight per requester, requester
// IDs tracked through a tag pipeline matched to the adder latency, results
// returned tagged with the owning requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave view of fpu_add_arbiter_if
//                (req_valid/req_a/req_b/req_ready/hold/busy,
//                 add_valid/add_a/add_b/add_res/add_ovf,
//                 rsp_valid/rsp_id/rsp_data/rsp_ovf)
// Handshake in cycle t -> add_valid at t+1 -> add_res at t+1+LAT ->
// rsp_valid at t+2+LAT.
// ---------------------------------------------------------------------------
module fpu_add_arbiter
    import fpu_pkg::*;
#(
    parameter  int unsigned K     = K_DEF,
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned LAT   = 3,
    localparam int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_add_arbiter_if.slave  bus
);

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_valid;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] busy_q, busy_d;
    logic [N_REQ-1:0] busy_set, busy_clr;

    // Stage 0 is the issue stage (drives add_valid); stage LAT lines up with
    // add_res from the adder.
    tag_t             tag_q [LAT+1];

    logic [K-1:0]     add_a_q, add_b_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [K-1:0]     rsp_data_q;
    logic             rsp_ovf_q;

    assign eligible = bus.req_valid & ~busy_q & {N_REQ{~bus.hold}};

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .eligible_i    (eligible),
        .ptr_i         (ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (gnt_idx),
        .grant_valid_o (gnt_valid)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_comb begin
        busy_set = grant;
        busy_clr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            busy_clr[i] = tag_q[LAT].valid && (tag_q[LAT].id == TAG_ID_W'(i));
        end
        busy_d = (busy_q | busy_set) & ~busy_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            for (int unsigned s = 0; s <= LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;

            tag_q[0].valid <= gnt_valid;
            tag_q[0].id    <= TAG_ID_W'(gnt_idx);
            for (int unsigned s = 1; s <= LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end

            if (gnt_valid) begin
                add_a_q <= bus.req_a[gnt_idx];
                add_b_q <= bus.req_b[gnt_idx];
            end

            // Response fields keep their last values between responses.
            rsp_valid_q <= tag_q[LAT].valid;
            if (tag_q[LAT].valid) begin
                rsp_id_q   <= tag_q[LAT].id[ID_W-1:0];
                rsp_data_q <= bus.add_res;
                rsp_ovf_q  <= bus.add_ovf;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.busy      = busy_q;
    assign bus.add_valid = tag_q[0].valid;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_ovf   = rsp_ovf_q;

    // A requester cannot be granted while its own op is still in flight.
    a_no_set_clr_same: assert property (
        @(posedge clk) disable iff (!rst_n) (busy_set & busy_clr) == '0
    );

endmodule

// File: tb/tb_fpu_add_arbiter.sv
module tb_fpu_add_arbiter;
    import fpu_pkg::*;

    localparam int unsigned K   = 64;
    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_add_arbiter_if #(.K(K), .N_REQ(N)) bus ();

    fpu_add_arbiter #(.K(K), .N_REQ(N), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference adder: IEEE double add, overflow when the result exponent saturates.
    function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction
    function automatic logic fovf(input logic [63:0] r);
        return &r[62:52];
    endfunction
    function automatic logic [63:0] rnd_op();
        return $realtobits(real'($urandom_range(0, 4000)) / 16.0 - 100.0);
    endfunction

    // Adder model: result appears LAT cycles after add_valid, updated mid-cycle.
    logic [64:0] adl [LAT+1];
    initial for (int i = 0; i <= LAT; i++) adl[i] = '0;
    always @(negedge clk) begin
        for (int k = LAT; k >= 1; k--) adl[k] = adl[k-1];
        adl[0]      = {fovf(fadd(bus.add_a, bus.add_b)), fadd(bus.add_a, bus.add_b)};
        bus.add_res = adl[LAT][63:0];
        bus.add_ovf = adl[LAT][64];
    end

    // Stimulus state
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  acc  = '0;
    logic [63:0]   op_a [N];
    logic [63:0]   op_b [N];
    always @(negedge clk) acc = bus.req_valid & bus.req_ready;

    // Scoreboard
    typedef struct {
        int unsigned id;
        logic [63:0] data;
        logic        ovf;
        longint      due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: cycles remaining until each requester is free again.
    int unsigned ptr_m;
    int unsigned rem [N];
    logic        addv_m;

    always @(negedge clk) begin : model
        int          w;
        logic [N-1:0] exp_busy;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            exp_q.delete();
            ptr_m  = 0;
            addv_m = 1'b0;
            for (int i = 0; i < N; i++) rem[i] = 0;
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_add_valid", 64'(bus.add_valid), 64'd0);
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        end else begin
            chk("add_valid", 64'(bus.add_valid), 64'(addv_m));
            for (int i = 0; i < N; i++) exp_busy[i] = (rem[i] > 0);
            chk("busy", 64'(bus.busy), 64'(exp_busy));
            w = -1;
            if (!bus.hold) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = int'((ptr_m + k) % N);
                    if (w < 0 && bus.req_valid[j] && rem[j] == 0) w = j;
                end
            end
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            for (int i = 0; i < N; i++) if (rem[i] > 0) rem[i]--;
            if (w >= 0) begin
                exp_q.push_back('{id: w, data: fadd(op_a[w], op_b[w]),
                                  ovf: fovf(fadd(op_a[w], op_b[w])), due: cyc + LAT + 2});
                rem[w] = LAT + 1;
                ptr_m  = (w + 1) % N;
                addv_m = 1'b1;
            end else begin
                addv_m = 1'b0;
            end
        end
    end

    // Monitor
    logic        seen = 1'b0;
    logic [63:0] last_data;
    int unsigned last_id;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(e.ovf));
            last_data = e.data;
            last_id   = e.id;
            seen      = 1'b1;
        end else begin
            chk("rsp_idle", 64'(bus.rsp_valid), 64'd0);
            if (seen) begin
                chk("rsp_hold_data", bus.rsp_data, last_data);
                chk("rsp_hold_id", 64'(bus.rsp_id), 64'(last_id));
            end
        end
    end

    task automatic drive();
        bus.req_valid = pend;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = op_a[i];
            bus.req_b[i] = op_b[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pend = pend & ~acc;
        drive();
    endtask

    task automatic post(input int i, input logic [63:0] a, input logic [63:0] b);
        op_a[i] = a;
        op_b[i] = b;
        pend[i] = 1'b1;
        drive();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((pend != '0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (pend != '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending %b outstanding %0d after %0d cycles",
                     pend, exp_q.size(), n);
        end
    endtask

    task automatic do_reset();
        pend     = '0;
        bus.hold = 1'b0;
        drive();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        bus.hold = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_rsp_data", bus.rsp_data, 64'd0);
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("reset_rsp_ovf", 64'(bus.rsp_ovf), 64'd0);
        chk("reset_add_a", bus.add_a, 64'd0);
        rst_n = 1'b1;
        step();

        // Single op: 1.0 + 2.0 from requester 1
        post(1, 64'h3FF0000000000000, 64'h4000000000000000);
        wait_idle(50);

        // Fairness: all four at once from ptr 0
        do_reset();
        for (int i = 0; i < N; i++) post(i, rnd_op(), rnd_op());
        wait_idle(50);

        // Pointer: lone grant to 2, then 0 and 3 together -> 3 first
        do_reset();
        post(2, rnd_op(), rnd_op());
        wait_idle(50);
        post(0, rnd_op(), rnd_op());
        post(3, rnd_op(), rnd_op());
        wait_idle(50);

        // Requester 0 keeps requesting: one op per LAT+2 cycles
        repeat (40) begin
            if (!pend[0]) post(0, rnd_op(), rnd_op());
            step();
        end
        wait_idle(50);

        // Overflow: max finite + max finite
        post(2, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF);
        wait_idle(50);

        // Hold with two ops in flight; resume from frozen pointer
        post(0, rnd_op(), rnd_op());
        post(1, rnd_op(), rnd_op());
        step();
        step();
        bus.hold = 1'b1;
        post(3, rnd_op(), rnd_op());
        post(2, rnd_op(), rnd_op());
        repeat (8) step();
        bus.hold = 1'b0;
        wait_idle(50);

        // Random soak with occasional hold
        repeat (300) begin
            bus.hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) post(i, rnd_op(), rnd_op());
            step();
        end
        bus.hold = 1'b0;
        wait_idle(100);

        // Reset mid-flight: nothing returns, first grant afterwards goes to 0
        post(0, rnd_op(), rnd_op());
        post(1, rnd_op(), rnd_op());
        step();
        step();
        step();
        step();
        pend = '0;
        drive();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        post(2, rnd_op(), rnd_op());
        post(0, rnd_op(), rnd_op());
        wait_idle(50);
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
